data_mem_responder: RTL and testbench

- Data-memory responder for the single-cycle LEGv8 CPU data bus: decodes DAB, serves reads onto the bidirectional DDB, and captures writes.
- Writes are posted into a one-entry write buffer and committed to the array on the following clock edge; reads bypass from the buffer.
- Flags illegal accesses through a sticky fault register and optionally counts accesses.
- Sits beside the instruction memory in the top-level testbench or SoC wrapper, opposite the CPU's MemRead/MemWrite/DAB/DDB pins.

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_wbuf.sv | 44 ++++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the LEGv8 data-memory responder.
// Holds the default bus width, the default array depth and the fault codes
// reported on fault_code.
package data_mem_responder_pkg;

  localparam int DMEM_WORD  = 64;
  localparam int DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10,
    FLT_CONFLICT = 2'b11
  } fault_code_e;

endpackage

// File: rtl/data_mem_responder_wbuf.sv
// One-entry posted write buffer for the data-memory responder.
// A captured write sits here for exactly one edge and is handed to the array
// on the next edge. Meanwhile, reads of the same index are served from here.
module dmem_wbuf #(
  parameter int WORD = 64,
  parameter int AW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_capture,
  input  logic [AW-1:0]   i_index,
  input  logic [WORD-1:0] i_data,
  input  logic [AW-1:0]   i_lookupIdx,
  output logic            o_hit,
  output logic [WORD-1:0] o_hitData,
  output logic            o_commit,
  output logic [AW-1:0]   o_commitIdx,
  output logic [WORD-1:0] o_commitData
);

  logic            r_valid;
  logic [AW-1:0]   r_index;
  logic [WORD-1:0] r_data;

  // Hold the newest legal write. Reset drops a pending entry without committing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_capture;
      if (i_capture) begin
        r_index <= i_index;
        r_data  <= i_data;
      end
    end
  end

  assign o_hit        = r_valid && (r_index == i_lookupIdx);
  assign o_hitData    = r_data;
  assign o_commit     = r_valid;
  assign o_commitIdx  = r_index;
  assign o_commitData = r_data;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle LEGv8 CPU.
// It decodes DAB and serves reads onto DDB in the same cycle. Writes are posted
// through a one-entry buffer. Illegal accesses set a sticky fault register.
// Optional macro DMEM_ACCESS_CNT_EN adds saturating legal read/write counters.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int              WORD      = DMEM_WORD,
  parameter int              DEPTH     = DMEM_DEPTH,
  parameter logic [WORD-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] DAB,
  inout  wire  [WORD-1:0] DDB,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            fault_clr,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [WORD-1:0] fault_addr,
  output logic [31:0]     rd_cnt,
  output logic [31:0]     wr_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD-1:0] r_mem [DEPTH];

  logic [WORD-1:0] w_off;
  logic            w_misalign;
  logic            w_outRange;
  logic [AW-1:0]   w_index;
  logic            w_conflict;
  logic            w_legalRead;
  logic            w_legalWrite;
  logic            w_illegalRead;
  logic            w_newFault;
  fault_code_e     w_newCode;
  logic            w_hit;
  logic [WORD-1:0] w_hitData;
  logic            w_commit;
  logic [AW-1:0]   w_commitIdx;
  logic [WORD-1:0] w_commitData;
  logic [WORD-1:0] w_readData;

  logic            r_fault;
  fault_code_e     r_faultCode;
  logic [WORD-1:0] r_faultAddr;

  // Because DEPTH is a power of two, "index >= DEPTH" is the same test as
  // "any offset bit above the index field is set".
  assign w_off      = DAB - BASE_ADDR;
  assign w_misalign = |w_off[2:0];
  assign w_outRange = |w_off[WORD-1:AW+3];
  assign w_index    = w_off[AW+2:3];

  assign w_conflict    = MemRead && MemWrite;
  assign w_legalRead   = MemRead && !MemWrite && !w_misalign && !w_outRange;
  assign w_legalWrite  = MemWrite && !MemRead && !w_misalign && !w_outRange;
  assign w_illegalRead = MemRead && !MemWrite && (w_misalign || w_outRange);

  // Classify this cycle's access. Conflict beats range, and range beats alignment.
  always_comb begin
    w_newFault = 1'b0;
    w_newCode  = FLT_NONE;
    if (w_conflict) begin
      w_newFault = 1'b1;
      w_newCode  = FLT_CONFLICT;
    end else if ((MemRead || MemWrite) && w_outRange) begin
      w_newFault = 1'b1;
      w_newCode  = FLT_RANGE;
    end else if ((MemRead || MemWrite) && w_misalign) begin
      w_newFault = 1'b1;
      w_newCode  = FLT_MISALIGN;
    end
  end

  dmem_wbuf #(
    .WORD (WORD),
    .AW   (AW)
  ) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .i_capture    (w_legalWrite),
    .i_index      (w_index),
    .i_data       (DDB),
    .i_lookupIdx  (w_index),
    .o_hit        (w_hit),
    .o_hitData    (w_hitData),
    .o_commit     (w_commit),
    .o_commitIdx  (w_commitIdx),
    .o_commitData (w_commitData)
  );

  // Retire the buffered entry into the array. Reset abandons it, so the
  // array keeps whatever that index held before.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      r_mem[w_commitIdx] <= w_commitData;
    end
  end

  // An illegal read gets a clean zero on the bus instead of floating.
  assign w_readData = w_hit ? w_hitData : r_mem[w_index];
  assign DDB = w_legalRead   ? w_readData :
               w_illegalRead ? '0         : 'z;

  // Sticky fault capture. A clear wins over a fault arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault     <= 1'b0;
      r_faultCode <= FLT_NONE;
      r_faultAddr <= '0;
    end else if (fault_clr) begin
      r_fault     <= 1'b0;
      r_faultCode <= FLT_NONE;
      r_faultAddr <= '0;
    end else if (w_newFault && !r_fault) begin
      r_fault     <= 1'b1;
      r_faultCode <= w_newCode;
      r_faultAddr <= DAB;
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_faultCode;
  assign fault_addr = r_faultAddr;

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] r_rdCnt;
  logic [31:0] r_wrCnt;

  // Saturating tallies of legal accesses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdCnt <= '0;
      r_wrCnt <= '0;
    end else begin
      if (w_legalRead && (r_rdCnt != 32'hFFFF_FFFF)) r_rdCnt <= r_rdCnt + 32'd1;
      if (w_legalWrite && (r_wrCnt != 32'hFFFF_FFFF)) r_wrCnt <= r_wrCnt + 32'd1;
    end
  end

  assign rd_cnt = r_rdCnt;
  assign wr_cnt = r_wrCnt;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// A behavioural model treats memory as a plain array that updates at the write
// edge. A reset on the very next edge undoes that write. Directed scenarios run
// first, followed by a randomized run.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] DAB = '0;
  wire  [63:0] DDB;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        fault_clr = 1'b0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [63:0] fault_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  logic        tbDrive = 1'b0;
  logic [63:0] tbData = '0;

  assign DDB = tbDrive ? tbData : 'z;

  data_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .DAB        (DAB),
    .DDB        (DDB),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_addr (fault_addr),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

`ifdef DMEM_ACCESS_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Memory as the CPU should see it, plus an undo record for the most recent write.
  logic [63:0] refMem   [256];
  bit          refKnown [256];
  bit          undoValid = 0;
  int          undoIdx   = 0;
  logic [63:0] undoOld   = '0;
  bit          undoKnown = 0;

  bit          mFault = 0;
  logic [1:0]  mCode  = 2'd0;
  logic [63:0] mAddr  = '0;
  longint      mRd    = 0;
  longint      mWr    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle, check the combinational read mid-cycle, advance the
  // model at the edge, and then check the registered outputs.
  task automatic applyStimulus(input bit rd, input bit wr, input bit clr, input bit rstIn,
                               input logic [63:0] addr, input logic [63:0] data);
    logic [63:0] off;
    bit          mis, oor, legalR, legalW, illegal;
    int          idx;
    logic [1:0]  code;
    off     = addr;
    mis     = (off % 8) != 0;
    oor     = (off / 8) >= 256;
    idx     = int'((off / 8) % 256);
    legalR  = rd && !wr && !mis && !oor;
    legalW  = wr && !rd && !mis && !oor;
    illegal = (rd && wr) || ((rd || wr) && (mis || oor));
    code    = (rd && wr) ? 2'd3 : oor ? 2'd2 : mis ? 2'd1 : 2'd0;

    MemRead   = rd;
    MemWrite  = wr;
    fault_clr = clr;
    rst       = rstIn;
    DAB       = addr;
    tbDrive   = wr && !rd;
    tbData    = data;

    @(negedge clk);
    if (rd && !wr && !rstIn) begin
      if (legalR) begin
        if (refKnown[idx]) checkOutput("read_data", DDB, refMem[idx]);
      end else begin
        checkOutput("illegal_read_zero", DDB, 64'h0);
      end
    end

    @(posedge clk);
    #1;
    if (rstIn) begin
      if (undoValid) begin
        refMem[undoIdx]   = undoOld;
        refKnown[undoIdx] = undoKnown;
      end
      undoValid = 0;
      mFault = 0; mCode = 2'd0; mAddr = '0; mRd = 0; mWr = 0;
    end else begin
      undoValid = 0;
      if (legalW) begin
        undoValid     = 1;
        undoIdx       = idx;
        undoOld       = refMem[idx];
        undoKnown     = refKnown[idx];
        refMem[idx]   = data;
        refKnown[idx] = 1;
        if (mWr < 64'hFFFF_FFFF) mWr++;
      end
      if (legalR && mRd < 64'hFFFF_FFFF) mRd++;
      if (clr) begin
        mFault = 0; mCode = 2'd0; mAddr = '0;
      end else if (illegal && !mFault) begin
        mFault = 1; mCode = code; mAddr = addr;
      end
    end
    checkOutput("fault", {63'd0, fault}, {63'd0, mFault});
    checkOutput("fault_code", {62'd0, fault_code}, {62'd0, mCode});
    checkOutput("fault_addr", fault_addr, mAddr);
    checkOutput("rd_cnt", {32'd0, rd_cnt}, CNT_ON ? mRd : 64'd0);
    checkOutput("wr_cnt", {32'd0, wr_cnt}, CNT_ON ? mWr : 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    int          op;
    for (int i = 0; i < 256; i++) begin
      refMem[i]   = '0;
      refKnown[i] = 0;
    end

    // Reset.
    applyStimulus(0, 0, 0, 1, 64'h0, 64'h0);
    applyStimulus(0, 0, 0, 1, 64'h0, 64'h0);
    checkOutput("reset_fault", {63'd0, fault}, 64'd0);

    // Write, then bypass read, then array read.
    applyStimulus(0, 1, 0, 0, 64'h10, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(1, 0, 0, 0, 64'h10, 64'h0);
    applyStimulus(0, 0, 0, 0, 64'h0, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h10, 64'h0);

    // Back-to-back writes to the same index.
    applyStimulus(0, 1, 0, 0, 64'h8, 64'h1);
    applyStimulus(0, 1, 0, 0, 64'h8, 64'h2);
    applyStimulus(1, 0, 0, 0, 64'h8, 64'h0);
    applyStimulus(0, 0, 0, 0, 64'h0, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h8, 64'h0);
    checkOutput("b2b_final", refMem[1], 64'h2);

    // Misaligned read, a masked range fault, a clear, and then a range fault.
    applyStimulus(1, 0, 0, 0, 64'h0C, 64'h0);
    checkOutput("misalign_code", {62'd0, fault_code}, 64'd1);
    applyStimulus(1, 0, 0, 0, 64'h800, 64'h0);
    checkOutput("sticky_addr", fault_addr, 64'h0C);
    applyStimulus(0, 0, 1, 0, 64'h0, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h800, 64'h0);
    checkOutput("range_code", {62'd0, fault_code}, 64'd2);

    // A read/write conflict must leave the array untouched.
    applyStimulus(0, 1, 1, 0, 64'h20, 64'h77);
    applyStimulus(0, 0, 0, 0, 64'h0, 64'h0);
    applyStimulus(1, 1, 0, 0, 64'h20, 64'h0);
    checkOutput("conflict_code", {62'd0, fault_code}, 64'd3);
    applyStimulus(0, 0, 0, 0, 64'h0, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h20, 64'h0);

    // A clear and a fault in the same cycle leave the flag clear.
    applyStimulus(1, 0, 1, 0, 64'h3, 64'h0);
    checkOutput("clr_priority", {63'd0, fault}, 64'd0);

    // A reset right after a write discards the buffered write.
    applyStimulus(0, 1, 0, 0, 64'h18, 64'hAAAA_5555_0000_FFFF);
    applyStimulus(0, 0, 0, 0, 64'h0, 64'h0);
    applyStimulus(0, 1, 0, 0, 64'h18, 64'h5);
    applyStimulus(0, 0, 0, 1, 64'h0, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h18, 64'h0);
    checkOutput("reset_discard", refMem[3], 64'hAAAA_5555_0000_FFFF);

    // Counters: 2 writes, 3 reads, and 1 faulting read after a reset.
    applyStimulus(0, 0, 0, 1, 64'h0, 64'h0);
    applyStimulus(0, 1, 0, 0, 64'h28, 64'h1111);
    applyStimulus(0, 1, 0, 0, 64'h30, 64'h2222);
    applyStimulus(1, 0, 0, 0, 64'h28, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h30, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h10, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h7, 64'h0);
    checkOutput("cnt_rd_total", {32'd0, rd_cnt}, CNT_ON ? 64'd3 : 64'd0);
    checkOutput("cnt_wr_total", {32'd0, wr_cnt}, CNT_ON ? 64'd2 : 64'd0);

    // Randomized traffic over a small index set so the bypass path gets exercised.
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 80)      a = 64'($urandom_range(0, 15)) * 8;
      else if (op < 90) a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(1, 7));
      else              a = 64'(256 + $urandom_range(0, 1000)) * 8;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0)
        applyStimulus(0, 0, 0, 1, a, 64'h0);
      else
        applyStimulus(op >= 2 && op <= 5 || op == 9, op >= 6,
                      $urandom_range(0, 15) == 0, 0, a, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
